// File: rtl/alu_issue.sv
// Issue/decode stage for RV32I OP and OP-IMM feeding a registered ALU, with register file and busy scoreboard.
// Optional macro ALU_ISSUE_WB_BYPASS_EN forwards same-cycle writeback data to the source operands.
module alu_issue #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [5:0]      alu_op,
  output logic [4:0]      alu_rd,
  output logic            illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy;

  logic            legal;
  logic            uses_rs2;
  logic            is_shift;
  logic [5:0]      dec_op;

  always_comb begin
    legal    = 1'b0;
    uses_rs2 = 1'b0;
    is_shift = 1'b0;
    dec_op   = 6'd0;
    case (opcode)
      OPC_OP: begin
        uses_rs2 = 1'b1;
        legal    = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: dec_op = 6'd0;
          {7'b0100000, 3'b000}: dec_op = 6'd1;
          {7'b0000000, 3'b100}: dec_op = 6'd2;
          {7'b0000000, 3'b110}: dec_op = 6'd3;
          {7'b0000000, 3'b111}: dec_op = 6'd4;
          {7'b0000000, 3'b001}: dec_op = 6'd5;
          {7'b0000000, 3'b101}: dec_op = 6'd6;
          {7'b0100000, 3'b101}: dec_op = 6'd7;
          {7'b0000000, 3'b010}: dec_op = 6'd8;
          {7'b0000000, 3'b011}: dec_op = 6'd9;
          default:              legal  = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        legal = 1'b1;
        case (funct3)
          3'b000: dec_op = 6'd10;
          3'b100: dec_op = 6'd11;
          3'b110: dec_op = 6'd12;
          3'b111: dec_op = 6'd13;
          3'b010: dec_op = 6'd17;
          3'b011: dec_op = 6'd18;
          3'b001: begin
            is_shift = 1'b1;
            if (funct7 == 7'b0000000) dec_op = 6'd14;
            else                      legal  = 1'b0;
          end
          default: begin
            is_shift = 1'b1;
            if (funct7 == 7'b0000000)      dec_op = 6'd15;
            else if (funct7 == 7'b0100000) dec_op = 6'd16;
            else                           legal  = 1'b0;
          end
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Busy state as seen after this cycle's writeback clear; x0 never participates.
  logic [NREG-1:0] wb_clr, busy_eff;
  logic            wb_hit1, wb_hit2;
  assign wb_clr   = (wb_en && wb_rd != 5'd0) ? (NREG'(1) << wb_rd) : '0;
  assign busy_eff = busy & ~wb_clr;
  assign wb_hit1  = wb_en && (wb_rd == rs1) && (rs1 != 5'd0);
  assign wb_hit2  = wb_en && (wb_rd == rs2) && (rs2 != 5'd0);

  logic            rs1_haz, rs2_haz, hazard, accept;
  logic [XLEN-1:0] rs1_val, rs2_val;

`ifdef ALU_ISSUE_WB_BYPASS_EN
  assign rs1_haz = busy_eff[rs1];
  assign rs2_haz = busy_eff[rs2];
  assign rs1_val = (rs1 == 5'd0) ? '0 : (wb_hit1 ? wb_data : rf[rs1]);
  assign rs2_val = (rs2 == 5'd0) ? '0 : (wb_hit2 ? wb_data : rf[rs2]);
`else
  // Without forwarding, a source being written this cycle waits one cycle for the file update.
  assign rs1_haz = busy[rs1] | wb_hit1;
  assign rs2_haz = busy[rs2] | wb_hit2;
  assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];
`endif

  assign hazard      = legal && (rs1_haz || (uses_rs2 && rs2_haz) || busy_eff[rd]);
  assign instr_ready = (!out_valid || out_ready) && !hazard;
  assign accept      = instr_valid && instr_ready;

  logic [XLEN-1:0] imm_val;
  assign imm_val = is_shift ? {{(XLEN-5){1'b0}}, instr[24:20]}
                            : {{(XLEN-12){instr[31]}}, instr[31:20]};

  logic [NREG-1:0] busy_set;
  assign busy_set = (accept && legal && rd != 5'd0) ? (NREG'(1) << rd) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      busy <= busy_eff | busy_set;
      if (wb_en && wb_rd != 5'd0) rf[wb_rd] <= wb_data;
    end
  end

  // Illegal ops still issue, but as an all-zero payload flagged by illegal.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_rd    <= '0;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      illegal   <= !legal;
      alu_op    <= legal ? dec_op : 6'd0;
      alu_rd    <= legal ? rd : 5'd0;
      alu_a     <= legal ? rs1_val : '0;
      alu_b     <= !legal ? '0 : (uses_rs2 ? rs2_val : imm_val);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue/decode stage directly upstream of the registered ALU; it produces that ALU's operands and op code.
- Accepts RV32I OP (0110011) and OP-IMM (0010011) instructions over a valid/ready handshake.
- Holds the 32x32 integer register file and a per-register busy scoreboard.
- Emits registered alu_a/alu_b/alu_op/alu_rd to the ALU; the writeback stage returns results on the wb port.

Parameters:
XLEN, 32, datapath width
NREG, 32, architectural registers (x0 hardwired zero)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted at 0, async assert, released synchronously to clock by the top level)
instr_valid  input  1  instruction available
instr  input  32  RV32I instruction word
instr_ready  output  1  stage accepts instr this cycle
out_valid  output  1  alu_* outputs hold an issued op
out_ready  input  1  ALU side consumes op this cycle
alu_a  output  XLEN  operand 1 (rs1 value)
alu_b  output  XLEN  operand 2 (rs2 value or immediate)
alu_op  output  6  ALU op code 0..18
alu_rd  output  5  destination register
illegal  output  1  issued op was undecodable
wb_en  input  1  writeback strobe
wb_rd  input  5  writeback register
wb_data  input  XLEN  writeback value

Behaviour:
- Reset (reset=0):
  - out_valid=0, alu_a=0, alu_b=0, alu_op=0, alu_rd=0, illegal=0.
  - All busy bits cleared; register file cleared to 0.
- Acceptance:
  - Accept = instr_valid && instr_ready.
  - instr_ready = (!out_valid || out_ready) && !hazard.
  - On accept, the output register loads next edge: 1-cycle latency.
  - If out_valid && out_ready without accept, out_valid drops to 0.
  - Outputs hold stable while out_valid && !out_ready.
- Hazard:
  - Stall if rs1 is busy, rs2 is busy (OP only), or rd is busy (WAW).
  - Busy is evaluated after this cycle's writeback clear.
  - x0 is never busy.
- Scoreboard:
  - wb_en clears busy[wb_rd].
  - Accept of a legal op with rd!=0 sets busy[rd].
  - Set and clear of the same register in one cycle: set wins.
- Register file:
  - wb_en with wb_rd!=0 writes wb_data at the edge; writes to x0 are ignored.
  - Reads of x0 return 0.
- OP decode (funct7, funct3 -> alu_op):
  - 0000000/000 -> 0 ADD; 0100000/000 -> 1 SUB.
  - 0000000/100 -> 2 XOR; 0000000/110 -> 3 OR; 0000000/111 -> 4 AND.
  - 0000000/001 -> 5 SLL; 0000000/101 -> 6 SRL; 0100000/101 -> 7 SRA.
  - 0000000/010 -> 8 SLT; 0000000/011 -> 9 SLTU.
  - alu_b = rs2 value.
- OP-IMM decode (funct3 -> alu_op):
  - 000 -> 10 ADDI; 100 -> 11 XORI; 110 -> 12 ORI; 111 -> 13 ANDI.
  - 010 -> 17 SLTI; 011 -> 18 SLTIU.
  - alu_b = sign-extended instr[31:20].
  - Shifts: 001 with funct7=0000000 -> 14 SLLI; 101 with 0000000 -> 15 SRLI; 101 with 0100000 -> 16 SRAI.
  - For shifts, alu_b = zero-extended instr[24:20].
- Illegal (any other opcode or funct7):
  - Accepted with no hazard check.
  - Issues illegal=1, alu_op=0, alu_a=0, alu_b=0, alu_rd=0.
  - No busy bit set.
- Reset mid-operation: the pending output is discarded and all busy bits clear; in-flight writebacks after reset release are simply written.

Optional Feature:
- Macro: ALU_ISSUE_WB_BYPASS_EN.
- Defined:
  - A source register written by wb this cycle is read as wb_data (bypass).
  - Its busy clear takes effect for this cycle's hazard check, so no stall.
- Undefined:
  - No bypass; a source matching wb_rd with wb_en set counts as a hazard for that cycle.
  - Issue occurs the following cycle from the register file (1 extra stall cycle).

Test Plan:
- Reset: hold reset=0 then release; issue ADDI x1,x0,-5 (0xFFB00093) -> next cycle out_valid=1, alu_op=10, alu_a=0, alu_b=0xFFFFFFFB, alu_rd=1; instr_ready drops for a dependent ADD x2,x1,x1 until wb_en, wb_rd=1, wb_data=0xFFFFFFFB.
- Dependent op with bypass: after that writeback, ADD x2,x1,x1 issues with alu_a=alu_b=0xFFFFFFFB, alu_op=0; with the macro defined, same-cycle wb gives zero stall; with it undefined, exactly one stall cycle.
- Decode sweep: all 19 legal encodings -> alu_op 0..18. SRAI x3,x4,31 (0x41F25193) -> alu_op=16, alu_b=31. SUB -> 1. SRA -> 7.
- Backpressure: out_ready=0 with two valid instructions -> first held stable, instr_ready=0; out_ready=1 -> back-to-back issue, one per cycle, no loss or duplication.
- Illegal/WAW/x0: opcode 0x0000007F -> illegal=1, alu_op=0, no stall. Second write to a busy rd stalls until its wb. ADDI x0,x0,1 never sets busy, and x0 always reads 0.
